// File: rtl/soc_mem_pipe_pkg.sv
// Shared definitions for the soc_mem_pipe on-chip SRAM block: latency limit,
// a constant-evaluable clog2 and the control half of the response record.
package soc_mem_pkg;

    localparam int MAX_READ_LATENCY = 3;

    // Ceiling log2, usable in localparam expressions; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Per-response control flags; the data field is attached where the
    // data width is known (see soc_mem_resp_pipe)
    typedef struct packed {
        logic valid;
        logic err;
    } resp_ctrl_t;

endpackage

// File: rtl/soc_mem_pipe_if.sv
// req/gnt/rvalid memory bus between a requester (master) and soc_mem_pipe (slave).
interface soc_mem_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 22
);
    logic                    ena;
    logic                    req;
    logic                    gnt;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    err;

    modport master (
        output ena, req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  ena, req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/soc_mem_pipe_resp_pipe.sv
// soc_mem_resp_pipe: LATENCY-deep shift register of {valid, err, rdata}
// responses. Every stage is registered and cleared by the async reset, so a
// reset drops all in-flight responses.
module soc_mem_resp_pipe
    import soc_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic                  in_err,
    input  logic [DATA_WIDTH-1:0] in_rdata,
    output logic                  out_valid,
    output logic                  out_err,
    output logic [DATA_WIDTH-1:0] out_rdata
);
    // Out-of-range latencies are clamped to the supported 1..MAX window
    localparam int DEPTH = (LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                           ((LATENCY < 1) ? 1 : LATENCY);

    typedef struct packed {
        resp_ctrl_t            ctrl;
        logic [DATA_WIDTH-1:0] rdata;
    } stage_t;

    stage_t stages [DEPTH];

    // Shift responses one stage per clock; stage 0 captures the accept edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0].ctrl.valid <= in_valid;
            stages[0].ctrl.err   <= in_err;
            stages[0].rdata      <= in_rdata;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign out_valid = stages[DEPTH-1].ctrl.valid;
    assign out_err   = stages[DEPTH-1].ctrl.err;
    assign out_rdata = stages[DEPTH-1].rdata;

endmodule

// File: rtl/soc_mem_pipe.sv
// soc_mem_pipe: parametrised on-chip SRAM with req/gnt/rvalid handshake,
// byte-lane writes, read-first reads, bounds checking and a fixed-latency
// in-order response pipeline.
// Optional usage counters are built when SOC_MEM_PERF_EN is defined.
module soc_mem_pipe
    import soc_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int WORDS        = 1024,
    parameter int ADDR_WIDTH   = 22,
    parameter int READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          resetn,
    soc_mem_pipe_if.slave bus
`ifdef SOC_MEM_PERF_EN
    ,
    input  logic          cnt_clr,
    output logic [31:0]   rd_count,
    output logic [31:0]   wr_count,
    output logic [15:0]   err_count
`endif
);
    localparam int NUM_BYTES   = DATA_WIDTH / 8;
    localparam int OFFSET_BITS = clog2(NUM_BYTES);
    localparam int INDEX_BITS  = ADDR_WIDTH - OFFSET_BITS;
    localparam int MEM_AW      = (clog2(WORDS) < 1) ? 1 : clog2(WORDS);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic [INDEX_BITS-1:0] word_idx;
    logic [MEM_AW-1:0]     mem_idx;
    logic                  accept;
    logic                  in_range;
    logic                  do_write;
    logic                  do_read;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  resp_err;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  pipe_valid;
    logic                  pipe_err;
    logic [DATA_WIDTH-1:0] pipe_rdata;

    // No back-pressure other than the block enable
    assign bus.gnt  = bus.ena;
    assign accept   = bus.req && bus.ena;

    // Sub-word address bits are dropped; misalignment is not an error
    assign word_idx = bus.addr[ADDR_WIDTH-1:OFFSET_BITS];
    assign mem_idx  = word_idx[MEM_AW-1:0];
    assign in_range = (33'(word_idx) < 33'(WORDS));

    assign do_write = accept && bus.we && in_range;
    assign do_read  = accept && !bus.we && in_range;

    // Read-first: the word is sampled before this edge's write lands
    assign rd_word    = mem[mem_idx];
    assign resp_err   = accept && !in_range;
    assign resp_rdata = do_read ? rd_word : '0;

    // Byte-lane writes into the storage array, which has no reset
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.be[i]) begin
                    mem[mem_idx][i*8 +: 8] <= bus.wdata[i*8 +: 8];
                end
            end
        end
    end

    soc_mem_resp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_resp_pipe (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (accept),
        .in_err    (resp_err),
        .in_rdata  (resp_rdata),
        .out_valid (pipe_valid),
        .out_err   (pipe_err),
        .out_rdata (pipe_rdata)
    );

    assign bus.rvalid = pipe_valid;
    assign bus.err    = pipe_err;
    assign bus.rdata  = pipe_rdata;

`ifdef SOC_MEM_PERF_EN
    // Usage counters, wrapping; a clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_count  <= '0;
            wr_count  <= '0;
            err_count <= '0;
        end else if (cnt_clr) begin
            rd_count  <= '0;
            wr_count  <= '0;
            err_count <= '0;
        end else begin
            if (do_read)  rd_count  <= rd_count + 32'd1;
            if (do_write) wr_count  <= wr_count + 32'd1;
            if (resp_err) err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_soc_mem_pipe.sv
// Testbench for soc_mem_pipe (WORDS=1000, READ_LATENCY=3). Stimulus pushes
// expected responses into a scoreboard; a negedge monitor pops and compares.
// Counter checks are compiled when SOC_MEM_PERF_EN is defined.
module tb_soc_mem_pipe;

    localparam int DW    = 32;
    localparam int AW    = 22;
    localparam int WORDS = 1000;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    soc_mem_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef SOC_MEM_PERF_EN
    logic        cnt_clr;
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic [15:0] err_count;
`endif

    soc_mem_pipe #(
        .DATA_WIDTH   (DW),
        .WORDS        (WORDS),
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus.slave)
`ifdef SOC_MEM_PERF_EN
        ,
        .cnt_clr   (cnt_clr),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .err_count (err_count)
`endif
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [WORDS];
    int          checks = 0;
    int          errors = 0;
    int          ncyc   = 0;
    int          ref_rd = 0;
    int          ref_wr = 0;
    int          ref_err = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     name, actual, expected, ncyc);
        end
    endtask

    // Reference model of one accepted request: storage as a word array
    task automatic modelAccept(input logic w, input logic [3:0] b,
                               input logic [21:0] a, input logic [31:0] d);
        int   idx;
        exp_t e;
        idx     = int'(a >> 2);
        e.due   = ncyc + LAT;
        e.err   = 1'b0;
        e.rdata = 32'h0;
        if (idx >= WORDS) begin
            e.err = 1'b1;
            ref_err++;
        end else if (w) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) ref_mem[idx][i*8 +: 8] = d[i*8 +: 8];
            ref_wr++;
        end else begin
            e.rdata = ref_mem[idx];
            ref_rd++;
        end
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic en, input logic rq, input logic w,
                                 input logic [3:0] b, input logic [21:0] a,
                                 input logic [31:0] d);
        @(negedge clk);
        #1;
        bus.ena   = en;
        bus.req   = rq;
        bus.we    = w;
        bus.be    = b;
        bus.addr  = a;
        bus.wdata = d;
        #1;
        checkOutput("gnt", {31'b0, bus.gnt}, {31'b0, en});
        if (en && rq) modelAccept(w, b, a, d);
    endtask

    task automatic wr(input logic [21:0] a, input logic [31:0] d, input logic [3:0] b);
        applyStimulus(1'b1, 1'b1, 1'b1, b, a, d);
    endtask

    task automatic rd(input logic [21:0] a);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, a, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 22'h0, 32'h0);
    endtask

    // Monitor: pop and compare on every rvalid, flag late or missing responses
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (sb.size() > 0 && sb[0].due < ncyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL missing_rvalid: got rvalid=0 expected a response at cycle %0d (now %0d)",
                     sb[0].due, ncyc);
            sb.delete(0);
        end
        if (bus.rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rvalid: got rvalid=1 expected no response (cycle %0d)",
                         ncyc);
            end else begin
                e = sb.pop_front();
                checkOutput("latency", 32'(ncyc), 32'(e.due));
                checkOutput("err", {31'b0, bus.err}, {31'b0, e.err});
                checkOutput("rdata", bus.rdata, e.rdata);
            end
        end else begin
            checkOutput("idle_rvalid", {31'b0, bus.rvalid}, 32'h0);
            checkOutput("idle_err", {31'b0, bus.err}, 32'h0);
            checkOutput("idle_rdata", bus.rdata, 32'h0);
        end
    end

    initial begin
        logic        en, rq, w;
        logic [3:0]  b;
        logic [19:0] widx;
        logic [1:0]  lo;
        int          sel;

        resetn    = 1'b1;
        bus.ena   = 1'b0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.be    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
`ifdef SOC_MEM_PERF_EN
        cnt_clr   = 1'b0;
`endif
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;
        idle(10);

        // byte-enable merge: expect 0xDE22BE44
        wr(22'h10, 32'hDEADBEEF, 4'hF);
        wr(22'h10, 32'h11223344, 4'h5);
        rd(22'h10);
        idle(LAT);

        // back-to-back pipelined reads
        for (int i = 0; i < 4; i++) wr(22'(i * 4), 32'hA0 + 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) rd(22'(i * 4));
        idle(LAT);

        // out-of-range boundary
        wr(22'(999 * 4), 32'h0BADF00D, 4'hF);
        wr(22'(1000 * 4), 32'hFFFFFFFF, 4'hF);
        rd(22'(1000 * 4));
        rd(22'(999 * 4));
        idle(LAT);

        // ena low: nothing granted, nothing returned
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 1'b1, 1'(i % 2), 4'hF, 22'(i * 4), 32'h5555AAAA);
        idle(LAT + 1);

        // preload the random address pools
        for (int i = 0; i < 32; i++) wr(22'(i * 4), $urandom, 4'hF);
        for (int i = 990; i < 1000; i++) wr(22'(i * 4), $urandom, 4'hF);

        // randomized traffic, including misaligned and out-of-range addresses
        for (int n = 0; n < 400; n++) begin
            en  = ($urandom_range(0, 9) != 0);
            rq  = ($urandom_range(0, 7) != 0);
            w   = 1'($urandom_range(0, 1));
            b   = 4'($urandom);
            lo  = 2'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 7)      widx = 20'($urandom_range(0, 31));
            else if (sel < 9) widx = 20'($urandom_range(990, 1005));
            else              widx = 20'($urandom_range(1006, 1048575));
            applyStimulus(en, rq, w, b, {widx, lo}, $urandom);
        end
        idle(LAT);

        // reset with a write and a read in flight
        wr(22'(5 * 4), 32'hC0FFEE05, 4'hF);
        rd(22'(6 * 4));
        @(negedge clk);
        #1;
        bus.req = 1'b0;
        resetn  = 1'b0;
        sb.delete();
        ref_rd  = 0;
        ref_wr  = 0;
        ref_err = 0;
        @(negedge clk);
        #1 resetn = 1'b1;
        idle(LAT + 2);
        rd(22'(5 * 4));
        idle(LAT);

`ifdef SOC_MEM_PERF_EN
        @(negedge clk);
        #1 cnt_clr = 1'b1;
        @(negedge clk);
        #1 cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) rd(22'(i * 4));
        for (int i = 0; i < 3; i++) wr(22'(i * 4 + 40), 32'h1234 + 32'(i), 4'hF);
        rd(22'(1000 * 4));
        wr(22'(2000 * 4), 32'h0, 4'hF);
        idle(1);
        checkOutput("rd_count", rd_count, 32'd5);
        checkOutput("wr_count", wr_count, 32'd3);
        checkOutput("err_count", {16'h0, err_count}, 32'd2);
        @(negedge clk);
        #1;
        cnt_clr   = 1'b1;
        bus.ena   = 1'b1;
        bus.req   = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = 22'h0;
        modelAccept(1'b0, 4'h0, 22'h0, 32'h0);
        @(negedge clk);
        #1;
        cnt_clr = 1'b0;
        bus.req = 1'b0;
        checkOutput("rd_count_clr", rd_count, 32'd0);
        checkOutput("wr_count_clr", wr_count, 32'd0);
        checkOutput("err_count_clr", {16'h0, err_count}, 32'd0);
        idle(LAT);
`endif

        idle(LAT + 2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d responses outstanding, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
